mem_access_unit: RTL and testbench

//  Sits between the EX/MEM pipeline register and DataMemory and drives DataMemory's MR/MW/Addr/WD.

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front end for DataMemory. It turns byte, halfword and word
//   requests from EX/MEM into whole-word DataMemory accesses. Load data is
//   sign- or zero-extended. A sub-word store becomes a read-modify-write:
//   the word is read and merged in the request cycle, which stalls the
//   pipeline. The merged word is written back in the following WRITE cycle.
//   Misaligned and out-of-range requests are rejected without touching memory.
//
// Ports
//   Clk, Rst_n      clock (rising edge), asynchronous active-low reset
//   ReqValid        memory op present in EX/MEM this cycle
//   ReqWrite        1=store, 0=load
//   ReqSize         00=byte, 01=half, 10=word, 11=illegal
//   ReqSigned       load extension: 1=sign, 0=zero
//   ReqAddr         byte address
//   ReqWData        store data, sub-word taken from the low bits
//   MR, MW          DataMemory read / write enables
//   Addr, WD        DataMemory word address and write data
//   RD              DataMemory combinational read data
//   Stall           hold EX/MEM and upstream this cycle
//   LoadData        registered, extended load result
//   LoadValid       1-cycle pulse when LoadData is new
//   Err, ErrCause   1-cycle reject pulse; cause 01=misaligned, 10=out of range
module mem_access_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        MR,
  output logic        MW,
  output logic [31:0] Addr,
  output logic [31:0] WD,
  input  logic [31:0] RD,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        Err,
  output logic [1:0]  ErrCause
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state, nextState;
  logic        misaligned, outOfRange, reqLive;
  logic        reject, accept, isLoad, isWordStore, isSubStore;
  logic [31:0] wordAddr;
  logic [31:0] wrAddr_p1, wrData_p1;

  // Little-endian lane extraction plus sign or zero extension.
  function automatic logic [31:0] extendLoad(input logic [31:0] rd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = sgn ? 32'(b) : {24'h0, b};
      2'b01:   r = sgn ? 32'(h) : {16'h0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the read word with the low store bits.
  function automatic logic [31:0] mergeStore(input logic [31:0] rd,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = rd;
    case (size)
      2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Request decode. Gating with Rst_n makes every memory-side strobe
  // drop the moment reset asserts, not just at the next edge.
  always_comb begin
    wordAddr    = {ReqAddr[31:2], 2'b00};
    misaligned  = (ReqSize == 2'b11) ||
                  (ReqSize == 2'b01 && ReqAddr[0]) ||
                  (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00);
    outOfRange  = {2'b00, ReqAddr[31:2]} >= 32'(MEM_WORDS);
    reqLive     = Rst_n && (state == IDLE) && ReqValid;
    reject      = reqLive && (misaligned || outOfRange);
    accept      = reqLive && !misaligned && !outOfRange;
    isLoad      = accept && !ReqWrite;
    isWordStore = accept && ReqWrite && (ReqSize == 2'b10);
    isSubStore  = accept && ReqWrite && (ReqSize != 2'b10);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (isSubStore) nextState = WRITE;
      WRITE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    MR    = isLoad || isSubStore;
    MW    = isWordStore || (state == WRITE && Rst_n);
    Stall = isSubStore;
    Addr  = (state == WRITE) ? wrAddr_p1 : wordAddr;
    WD    = (state == WRITE) ? wrData_p1 : ReqWData;
  end

  // ---- request cycle -> p1: load result, reject status ----
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      LoadData  <= 32'h0;
      LoadValid <= 1'b0;
      Err       <= 1'b0;
      ErrCause  <= 2'b00;
    end else begin
      LoadValid <= isLoad;
      Err       <= reject;
      if (isLoad)
        LoadData <= extendLoad(RD, ReqSize, ReqAddr[1:0], ReqSigned);
      // Misaligned wins over out of range.
      if (reject)
        ErrCause <= misaligned ? 2'b01 : 2'b10;
    end
  end

  // ---- request cycle -> p1: merged word held for the WRITE cycle ----
  always_ff @(posedge Clk) begin
    if (isSubStore) begin
      wrAddr_p1 <= wordAddr;
      wrData_p1 <= mergeStore(RD, ReqWData, ReqSize, ReqAddr[1:0]);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        Clk;
  logic        Rst_n;
  logic        ReqValid;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        MR;
  logic        MW;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Stall;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        Err;
  logic [1:0]  ErrCause;

  int passCount  = 0;
  int totalCount = 0;

  logic [31:0] mem [0:255];

  mem_access_unit #(.MEM_WORDS(256)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .MR(MR), .MW(MW), .Addr(Addr), .WD(WD), .RD(RD),
    .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid), .Err(Err),
    .ErrCause(ErrCause)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // DataMemory model: combinational read, write on rising edge.
  assign RD = mem[Addr[9:2]];
  always @(posedge Clk) if (MW) mem[Addr[9:2]] <= WD;

  task automatic setReq(input logic v, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] d);
    ReqValid = v; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = d;
  endtask

  task automatic setIdle();
    setReq(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // Preload a word through the DUT's own word-store path.
  task automatic wordStore(input logic [31:0] a, input logic [31:0] d);
    setReq(1'b1, 1'b1, 2'b10, 1'b0, a, d);
    @(posedge Clk); #1;
    setIdle();
  endtask

  task automatic test_reset();
    setIdle();
    Rst_n = 1'b1;
    #2 Rst_n = 1'b0;
    #1;
    totalCount++; if (LoadData !== 32'h0) $display("FAIL rst_loaddata got %h exp %h", LoadData, 32'h0); else passCount++;
    totalCount++; if (LoadValid !== 1'b0) $display("FAIL rst_loadvalid got %b exp 0", LoadValid); else passCount++;
    totalCount++; if (Err !== 1'b0) $display("FAIL rst_err got %b exp 0", Err); else passCount++;
    totalCount++; if (ErrCause !== 2'b00) $display("FAIL rst_errcause got %b exp 00", ErrCause); else passCount++;
    totalCount++; if ({MR, MW, Stall} !== 3'b000) $display("FAIL rst_strobes got %b exp 000", {MR, MW, Stall}); else passCount++;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_word_store_load();
    setReq(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge Clk);
    totalCount++; if (MW !== 1'b1) $display("FAIL ws_mw got %b exp 1", MW); else passCount++;
    totalCount++; if (Addr !== 32'h10) $display("FAIL ws_addr got %h exp %h", Addr, 32'h10); else passCount++;
    totalCount++; if (WD !== 32'hDEADBEEF) $display("FAIL ws_wd got %h exp %h", WD, 32'hDEADBEEF); else passCount++;
    totalCount++; if ({Stall, MR} !== 2'b00) $display("FAIL ws_stall_mr got %b exp 00", {Stall, MR}); else passCount++;
    @(posedge Clk); #1;
    setReq(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge Clk);
    totalCount++; if (MR !== 1'b1) $display("FAIL wl_mr got %b exp 1", MR); else passCount++;
    @(posedge Clk); #1;
    totalCount++; if (LoadData !== 32'hDEADBEEF) $display("FAIL wl_data got %h exp %h", LoadData, 32'hDEADBEEF); else passCount++;
    totalCount++; if (LoadValid !== 1'b1) $display("FAIL wl_valid got %b exp 1", LoadValid); else passCount++;
    setIdle();
    @(posedge Clk); #1;
    totalCount++; if (LoadValid !== 1'b0) $display("FAIL idle_valid got %b exp 0", LoadValid); else passCount++;
    totalCount++; if (LoadData !== 32'hDEADBEEF) $display("FAIL hold_data got %h exp %h", LoadData, 32'hDEADBEEF); else passCount++;
  endtask

  task automatic test_byte_rmw();
    wordStore(32'h10, 32'h11223344);
    setReq(1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAB);
    @(negedge Clk);
    totalCount++; if ({MR, Stall, MW} !== 3'b110) $display("FAIL brmw_c0 got %b exp 110", {MR, Stall, MW}); else passCount++;
    @(posedge Clk); #1;
    totalCount++; if ({MW, Stall, MR} !== 3'b100) $display("FAIL brmw_c1 got %b exp 100", {MW, Stall, MR}); else passCount++;
    totalCount++; if (WD !== 32'h11AB3344) $display("FAIL brmw_wd got %h exp %h", WD, 32'h11AB3344); else passCount++;
    totalCount++; if (Addr !== 32'h10) $display("FAIL brmw_addr got %h exp %h", Addr, 32'h10); else passCount++;
    @(posedge Clk); #1;
    // Load in the cycle right after WRITE sees the written word.
    setReq(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge Clk);
    totalCount++; if (MR !== 1'b1) $display("FAIL after_wr_mr got %b exp 1", MR); else passCount++;
    @(posedge Clk); #1;
    totalCount++; if (LoadData !== 32'h11AB3344) $display("FAIL after_wr_data got %h exp %h", LoadData, 32'h11AB3344); else passCount++;
    setIdle();
  endtask

  task automatic test_half_rmw();
    wordStore(32'h14, 32'hAABBCCDD);
    setReq(1'b1, 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234);
    @(negedge Clk);
    totalCount++; if (Stall !== 1'b1) $display("FAIL hrmw_stall got %b exp 1", Stall); else passCount++;
    @(posedge Clk); #1;
    totalCount++; if (WD !== 32'h1234CCDD) $display("FAIL hrmw_wd got %h exp %h", WD, 32'h1234CCDD); else passCount++;
    setIdle();
    @(posedge Clk); #1;
    totalCount++; if (mem[5] !== 32'h1234CCDD) $display("FAIL hrmw_mem got %h exp %h", mem[5], 32'h1234CCDD); else passCount++;
  endtask

  // Relies on mem[4]=0x11AB3344 and mem[5]=0x1234CCDD from the RMW tests.
  task automatic test_extension();
    logic [1:0]  sz  [6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    logic        sg  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad  [6] = '{32'h12, 32'h12, 32'h16, 32'h15, 32'h14, 32'h14};
    logic [31:0] exp [6] = '{32'hFFFFFFAB, 32'h000011AB, 32'h00001234,
                             32'hFFFFFFCC, 32'h000000DD, 32'hFFFFCCDD};
    for (int i = 0; i < 6; i++) begin
      setReq(1'b1, 1'b0, sz[i], sg[i], ad[i], 32'h0);
      @(posedge Clk); #1;
      totalCount++; if (LoadData !== exp[i] || LoadValid !== 1'b1)
        $display("FAIL ext_%0d got %h/%b exp %h/1", i, LoadData, LoadValid, exp[i]);
      else passCount++;
    end
    setIdle();
  endtask

  task automatic test_errors();
    logic [1:0]  sz  [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    logic        wr  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ad  [5] = '{32'h13, 32'h400, 32'h0, 32'h400, 32'h402};
    logic [1:0]  cau [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 5; i++) begin
      setReq(1'b1, wr[i], sz[i], 1'b0, ad[i], 32'h12345678);
      @(negedge Clk);
      totalCount++; if ({MR, MW, Stall} !== 3'b000) $display("FAIL err_strobes_%0d got %b exp 000", i, {MR, MW, Stall}); else passCount++;
      @(posedge Clk); #1;
      totalCount++; if ({Err, LoadValid} !== 2'b10) $display("FAIL err_pulse_%0d got %b exp 10", i, {Err, LoadValid}); else passCount++;
      totalCount++; if (ErrCause !== cau[i]) $display("FAIL err_cause_%0d got %b exp %b", i, ErrCause, cau[i]); else passCount++;
    end
    setIdle();
    @(posedge Clk); #1;
    totalCount++; if (Err !== 1'b0) $display("FAIL err_drop got %b exp 0", Err); else passCount++;
    totalCount++; if (ErrCause !== 2'b01) $display("FAIL err_hold got %b exp 01", ErrCause); else passCount++;
    // Last legal word index.
    wordStore(32'h3FC, 32'h5A5A0001);
    setReq(1'b1, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    @(posedge Clk); #1;
    totalCount++; if ({LoadValid, Err} !== 2'b10) $display("FAIL edge_flags got %b exp 10", {LoadValid, Err}); else passCount++;
    totalCount++; if (LoadData !== 32'h5A5A0001) $display("FAIL edge_data got %h exp %h", LoadData, 32'h5A5A0001); else passCount++;
    setIdle();
  endtask

  task automatic test_reset_mid_rmw();
    wordStore(32'h10, 32'h11223344);
    setReq(1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
    @(posedge Clk); #1;
    totalCount++; if (MW !== 1'b1) $display("FAIL rrmw_write got %b exp 1", MW); else passCount++;
    #2 Rst_n = 1'b0;
    #1;
    totalCount++; if ({MW, MR, Stall} !== 3'b000) $display("FAIL rrmw_drop got %b exp 000", {MW, MR, Stall}); else passCount++;
    totalCount++; if (LoadData !== 32'h0) $display("FAIL rrmw_loaddata got %h exp 0", LoadData); else passCount++;
    setIdle();
    @(posedge Clk); #1;
    totalCount++; if (mem[4] !== 32'h11223344) $display("FAIL rrmw_mem got %h exp %h", mem[4], 32'h11223344); else passCount++;
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
    setReq(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge Clk);
    totalCount++; if ({MR, MW} !== 2'b10) $display("FAIL rrmw_idle got %b exp 10", {MR, MW}); else passCount++;
    @(posedge Clk); #1;
    totalCount++; if (LoadData !== 32'h11223344) $display("FAIL rrmw_reload got %h exp %h", LoadData, 32'h11223344); else passCount++;
    setIdle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] val [3] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
    wordStore(32'h0, val[0]);
    wordStore(32'h4, val[1]);
    wordStore(32'h8, val[2]);
    for (int i = 0; i < 3; i++) begin
      setReq(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
      @(negedge Clk);
      totalCount++; if (Stall !== 1'b0) $display("FAIL b2b_stall_%0d got %b exp 0", i, Stall); else passCount++;
      @(posedge Clk); #1;
      totalCount++; if (LoadValid !== 1'b1 || LoadData !== val[i])
        $display("FAIL b2b_load_%0d got %h/%b exp %h/1", i, LoadData, LoadValid, val[i]);
      else passCount++;
    end
    setIdle();
    @(posedge Clk); #1;
    totalCount++; if (LoadValid !== 1'b0) $display("FAIL b2b_end got %b exp 0", LoadValid); else passCount++;
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_half_rmw();
    test_extension();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
